// File: rtl/counter_pkg.sv
// Shared types for the counter slice collector: widths, FSM states and the slice result payload.
package counter_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Sum is carried at full counter width; the collector narrows it to SUM_W on output.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] sum;
    logic [CNT_W-1:0] max;
  } slice_result_t;

endpackage

// File: rtl/slice_accumulator.sv
// Per-slice sum/max/element-count datapath; strobes complete_c on the sample that closes a slice.
// Optional macro COLLECTOR_SAT_EN makes the sum saturate and reports it on sat_c.
module slice_accumulator
  import counter_pkg::*;
#(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned SUM_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] sample,
  output logic             complete_c,
  output logic [SUM_W-1:0] sum_c,
  output logic [CNT_W-1:0] max_c,
  output logic             sat_c
);

  logic [IDX_W-1:0] elem_cnt_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] max_q;
  logic [SUM_W-1:0] addend;

  assign addend = sample[SUM_W-1:0];

`ifdef COLLECTOR_SAT_EN
  logic             sat_q;
  logic [SUM_W:0]   sum_wide;

  // A carry out of the SUM_W-bit sum means the slice has saturated.
  assign sum_wide = {1'b0, sum_q} + {1'b0, addend};
  assign sum_c    = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
  assign sat_c    = sat_q | sum_wide[SUM_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sat_q <= 1'b0;
    end else if (sample_en) begin
      sat_q <= complete_c ? 1'b0 : sat_c;
    end
  end
`else
  assign sum_c = sum_q + addend;
  assign sat_c = 1'b0;
`endif

  assign max_c      = (sample > max_q) ? sample : max_q;
  assign complete_c = sample_en && (elem_cnt_q == IDX_W'(NUM_COUNTER - 1));

  // Running accumulators; they restart from zero once a slice closes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      elem_cnt_q <= '0;
      sum_q      <= '0;
      max_q      <= '0;
    end else if (sample_en) begin
      if (complete_c) begin
        elem_cnt_q <= '0;
        sum_q      <= '0;
        max_q      <= '0;
      end else begin
        elem_cnt_q <= elem_cnt_q + IDX_W'(1);
        sum_q      <= sum_c;
        max_q      <= max_c;
      end
    end
  end

endmodule

// File: rtl/counter_slice_collector.sv
// Groups a counter stream into slices and presents per-slice sum/max on a valid/ready register.
// Optional macro COLLECTOR_SAT_EN: saturating slice sum, saturation also raises Overflow.
module counter_slice_collector
  import counter_pkg::*;
#(
  parameter int unsigned NUM_COUNTER = 10,
  parameter int unsigned NUM_SLICE   = 2,
  parameter int unsigned SUM_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Counter,
  input  logic             Out_Ready,
  output logic             Out_Valid,
  output logic [7:0]       Slice_Idx,
  output logic [SUM_W-1:0] Slice_Sum,
  output logic [31:0]      Slice_Max,
  output logic             Overflow,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] slice_cnt_q, slice_cnt_d;
  slice_result_t    res_q, res_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             sample_en_c;
  logic             transfer_c;
  logic             complete_c;
  logic [SUM_W-1:0] acc_sum_c;
  logic [CNT_W-1:0] acc_max_c;
  logic             acc_sat_c;

  assign sample_en_c = (state_q == ACCUM) && (Counter != '0);
  assign transfer_c  = valid_q && Out_Ready;

  slice_accumulator #(
    .NUM_COUNTER (NUM_COUNTER),
    .SUM_W       (SUM_W)
  ) u_acc (
    .Clk        (Clk),
    .Reset      (Reset),
    .sample_en  (sample_en_c),
    .sample     (Counter),
    .complete_c (complete_c),
    .sum_c      (acc_sum_c),
    .max_c      (acc_max_c),
    .sat_c      (acc_sat_c)
  );

  // Next-state, output register and sticky overflow.
  always_comb begin
    state_d     = state_q;
    slice_cnt_d = slice_cnt_q;
    res_d       = res_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;

    if (transfer_c) valid_d = 1'b0;

    if (complete_c) begin
      slice_cnt_d = slice_cnt_q + IDX_W'(1);
      // A held, unaccepted result wins; the new one is dropped.
      if (valid_q && !Out_Ready) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        res_d   = '{idx: slice_cnt_q, sum: CNT_W'(acc_sum_c), max: acc_max_c};
      end
      if (acc_sat_c) ovf_d = 1'b1;
    end

    case (state_q)
      ACCUM:   if (slice_cnt_d == IDX_W'(NUM_SLICE)) state_d = DRAIN;
      DRAIN:   if (!valid_q || transfer_c) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = ACCUM;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ACCUM;
      slice_cnt_q <= '0;
      res_q       <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_cnt_q <= slice_cnt_d;
      res_q       <= res_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign Out_Valid = valid_q;
  assign Slice_Idx = res_q.idx;
  assign Slice_Sum = SUM_W'(res_q.sum);
  assign Slice_Max = res_q.max;
  assign Overflow  = ovf_q;
  assign Done      = done_q;

endmodule
